ball_pair_collision_scanner: RTL
================================

BALL_PAIR_COLLISION_SCANNER -- requirements
Module: ball_pair_collision_scanner

Interface
REQ-001 SHALL have parameter NUM_BALLS, 6, highest ball index (balls 0..NUM_BALLS, 7 balls, 21 pairs).
REQ-002 SHALL have parameter SQUARE_BALLS_CENTER_DIST, 1024, squared center distance threshold (32*32).
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port resetN  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port startOfFrame  in  1  one-cycle frame pulse that starts a scan.
REQ-006 SHALL have port topLeftX_VEC_in  in  [NUM_BALLS:0][10:0] signed  ball top-left X.
REQ-007 SHALL have port topLeftY_VEC_in  in  [NUM_BALLS:0][10:0] signed  ball top-left Y.
REQ-008 SHALL have port ball_active  in  [NUM_BALLS:0]  1 = ball on table; 0 = pocketed, excluded.
REQ-009 SHALL have port balls_collide  out  [NUM_BALLS:0]  two bits set for the presented pair, else 0.
REQ-010 SHALL have port Balls_col_ID  out  [1:0][3:0]  [0] = lower ID, [1] = higher ID of the presented pair.
REQ-011 SHALL have port col_valid  out  1  high in exactly the cycle a pair is presented.
REQ-012 SHALL have port scan_done  out  1  one-cycle pulse when a scan finishes.

Function
REQ-013 SHALL implement FSM IDLE, SCAN, PRESENT, DONE; reset state IDLE.
REQ-014 IDLE: on startOfFrame=1, SHALL snapshot both coordinate vectors and ball_active into registers, set pair counters (i,j)=(0,1), and go to SCAN.
REQ-015 SCAN SHALL evaluate one pair per cycle from the snapshot, in order (0,1),(0,2)..(0,6),(1,2)..(5,6).
REQ-016 Pair test SHALL use dx = X[j]-X[i] and dy = Y[j]-Y[i] as signed 11 bit, and d2 = dx*dx + dy*dy at 22 bit unsigned with no truncation; hit when d2 < SQUARE_BALLS_CENTER_DIST (strict).
REQ-017 Pair with either ball inactive SHALL count as no hit.
REQ-018 SHALL keep a 21-bit contact memory, one bit per pair; a hit with bit=0 is a new collision, sets the bit, and goes to PRESENT.
REQ-019 A hit with bit=1 SHALL be suppressed: no present, bit stays 1, continue SCAN.
REQ-020 A no-hit SHALL clear that pair's bit.
REQ-021 PRESENT SHALL last exactly one cycle with registered outputs: col_valid=1, Balls_col_ID={j,i} ([0]=i, [1]=j), balls_collide bits i and j set.
REQ-022 After PRESENT, the FSM SHALL go to SCAN at the next pair, or to DONE if the presented pair was (5,6).
REQ-023 After pair (5,6) is evaluated with no new collision, the FSM SHALL go to DONE.
REQ-024 DONE SHALL assert scan_done=1 for one cycle, then go to IDLE.
REQ-025 Outside PRESENT, col_valid, balls_collide and Balls_col_ID SHALL be 0.
REQ-026 Latency: with startOfFrame high in cycle t, pair (0,1) SHALL be evaluated in t+1; a scan with k new collisions SHALL pulse scan_done in cycle t+22+k.
REQ-027 startOfFrame SHALL be ignored outside IDLE; there is no restart and no queueing.
REQ-028 Coordinate or ball_active changes during a scan SHALL NOT affect it; only the snapshot is used.

Reset
REQ-029 On resetN=0 at a clock edge: state IDLE, all outputs 0, counters (0,1), contact memory 0, snapshot 0.
REQ-030 Reset asserted mid-scan SHALL abort the scan with no scan_done; the next startOfFrame starts a fresh scan with empty contact memory.

Verification
REQ-031 Ball0 (100,100), ball1 (120,110), others far apart, all active, startOfFrame at t -> col_valid=1 in t+2 only, IDs {1,0}, balls_collide=7'b0000011, scan_done in t+23.
REQ-032 Threshold: ball1 at (132,100) (d2=1024) -> no col_valid, scan_done at t+22; ball1 at (131,100) (d2=961) -> pair (0,1) presented.
REQ-033 Contact memory: same positions as REQ-031 over three frames -> present in frame 1 only; move ball1 to (200,100) for one frame, then back -> present again.
REQ-034 Ball0 overlapping ball1 with ball_active[1]=0 -> no present; pairs (2,3) and (4,6) overlapping -> two presents in scan order, (2,3) first, scan_done at t+24.
REQ-035 startOfFrame pulsed again during SCAN -> ignored, exactly one scan_done; resetN=0 mid-scan -> outputs 0 next cycle, no scan_done until a new startOfFrame.

Source files
------------

// File: rtl/ball_pair_collision_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ball_pair_collision_scanner                                                 |
// | Per-frame scan of every ball pair, one pair per cycle, reporting new        |
// | contacts one at a time.                                                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ball_pair_collision_scanner #(
  parameter int NUM_BALLS                = 6,
  parameter int SQUARE_BALLS_CENTER_DIST = 1024
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            startOfFrame,
  input  logic signed [NUM_BALLS:0][10:0] topLeftX_VEC_in,
  input  logic signed [NUM_BALLS:0][10:0] topLeftY_VEC_in,
  input  logic [NUM_BALLS:0]              ball_active,
  output logic [NUM_BALLS:0]              balls_collide,
  output logic [1:0][3:0]                 Balls_col_ID,
  output logic                            col_valid,
  output logic                            scan_done
);

  localparam int c_NB     = NUM_BALLS + 1;
  localparam int c_IW     = $clog2(c_NB);
  localparam int c_NPAIRS = (c_NB * NUM_BALLS) / 2;
  localparam int c_PW     = $clog2(c_NPAIRS);
  localparam logic [21:0] c_THRESH = 22'(SQUARE_BALLS_CENTER_DIST);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_SCAN    = 2'd1;
  localparam logic [1:0] c_PRESENT = 2'd2;
  localparam logic [1:0] c_DONE    = 2'd3;

  logic [1:0]              r_state;
  logic [1:0]              w_next;
  logic [NUM_BALLS:0][10:0] r_x;
  logic [NUM_BALLS:0][10:0] r_y;
  logic [NUM_BALLS:0]      r_act;
  logic [c_IW-1:0]         r_i;
  logic [c_IW-1:0]         r_j;
  logic [c_IW-1:0]         r_pi;
  logic [c_IW-1:0]         r_pj;
  logic [c_PW-1:0]         r_pidx;
  logic [c_NPAIRS-1:0]     r_mem;
  logic                    r_pres_last;

  logic signed [10:0]      w_dx;
  logic signed [10:0]      w_dy;
  logic signed [21:0]      w_dx2;
  logic signed [21:0]      w_dy2;
  logic [21:0]             w_d2;
  logic                    w_hit;
  logic                    w_new;
  logic                    w_last;

  // Differences wrap at 11 bits; squares are formed at full 22-bit width.
  always_comb begin
    w_dx  = $signed(r_x[r_j]) - $signed(r_x[r_i]);
    w_dy  = $signed(r_y[r_j]) - $signed(r_y[r_i]);
    w_dx2 = $signed({{11{w_dx[10]}}, w_dx}) * $signed({{11{w_dx[10]}}, w_dx});
    w_dy2 = $signed({{11{w_dy[10]}}, w_dy}) * $signed({{11{w_dy[10]}}, w_dy});
    w_d2  = $unsigned(w_dx2) + $unsigned(w_dy2);
    w_hit = r_act[r_i] & r_act[r_j] & (w_d2 < c_THRESH);
    w_new = w_hit & ~r_mem[r_pidx];
    w_last = (r_i == c_IW'(NUM_BALLS - 1)) && (r_j == c_IW'(NUM_BALLS));
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (startOfFrame) begin
          w_next = c_SCAN;
        end
      end
      c_SCAN: begin
        if (w_new) begin
          w_next = c_PRESENT;
        end else if (w_last) begin
          w_next = c_DONE;
        end
      end
      c_PRESENT: w_next = r_pres_last ? c_DONE : c_SCAN;
      c_DONE:    w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
  end

  // Contact memory persists across frames so a resting contact reports once.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_x         <= '0;
      r_y         <= '0;
      r_act       <= '0;
      r_i         <= '0;
      r_j         <= c_IW'(1);
      r_pi        <= '0;
      r_pj        <= '0;
      r_pidx      <= '0;
      r_mem       <= '0;
      r_pres_last <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (startOfFrame) begin
            r_x    <= topLeftX_VEC_in;
            r_y    <= topLeftY_VEC_in;
            r_act  <= ball_active;
            r_i    <= '0;
            r_j    <= c_IW'(1);
            r_pidx <= '0;
          end
        end
        c_SCAN: begin
          if (w_new) begin
            r_mem[r_pidx] <= 1'b1;
            r_pi          <= r_i;
            r_pj          <= r_j;
            r_pres_last   <= w_last;
          end else if (!w_hit) begin
            r_mem[r_pidx] <= 1'b0;
          end
          if (!w_last) begin
            r_pidx <= r_pidx + c_PW'(1);
            if (r_j == c_IW'(NUM_BALLS)) begin
              r_i <= r_i + c_IW'(1);
              r_j <= r_i + c_IW'(2);
            end else begin
              r_j <= r_j + c_IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    col_valid     = 1'b0;
    scan_done     = 1'b0;
    balls_collide = '0;
    Balls_col_ID  = '0;
    case (r_state)
      c_PRESENT: begin
        col_valid           = 1'b1;
        Balls_col_ID[0]     = 4'(r_pi);
        Balls_col_ID[1]     = 4'(r_pj);
        balls_collide[r_pi] = 1'b1;
        balls_collide[r_pj] = 1'b1;
      end
      c_DONE:  scan_done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
